// File: rtl/uart_msg_tx_pkg.sv
// Shared UART message constants and the state encoding for the message serialiser.
// UART_MSG_TX_CHECKSUM_EN adds the CSUM state.
package uart_msg_tx_pkg;

    localparam int UART_MSG_BITS  = 32;
    localparam int UART_MSG_BYTES = UART_MSG_BITS / 8;
    localparam int CSUM_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
`ifdef UART_MSG_TX_CHECKSUM_EN
        ST_CSUM = 2'd2,
`endif
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_msg_tx.sv
// Serialises one controller message LSB byte first onto a valid/ready byte link, then idles for a gap.
// UART_MSG_TX_CHECKSUM_EN appends an XOR checksum byte after the payload.
module uart_msg_tx
    import uart_msg_tx_pkg::*;
#(
    parameter int MSG_BYTES  = UART_MSG_BYTES,
    parameter int GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [MSG_BYTES*8-1:0] uart_out_msg,
    input  logic                   uart_out_req,
    output logic                   uart_out_ready,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy
);

    localparam int BW = $clog2(MSG_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(MSG_BYTES - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);
    localparam state_e POST_ST = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_e                 state_q, state_d;
    logic [MSG_BYTES*8-1:0] shift_q, shift_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [GW-1:0]          gcnt_q, gcnt_d;
    // Keeps ready low until the first clock edge after reset release.
    logic                   init_q;
`ifdef UART_MSG_TX_CHECKSUM_EN
    logic [CSUM_W-1:0]      csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            init_q  <= 1'b0;
`ifdef UART_MSG_TX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            init_q  <= 1'b1;
`ifdef UART_MSG_TX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bcnt_d         = bcnt_q;
        gcnt_d         = gcnt_q;
        uart_out_ready = 1'b0;
        tx_valid       = 1'b0;
        tx_byte        = '0;
`ifdef UART_MSG_TX_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                uart_out_ready = init_q;
                if (uart_out_req && init_q) begin
                    shift_d = uart_out_msg;
                    bcnt_d  = '0;
                    state_d = ST_SEND;
`ifdef UART_MSG_TX_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_byte  = shift_q[7:0];
                if (tx_ready) begin
                    shift_d = shift_q >> 8;
                    bcnt_d  = bcnt_q + BW'(1);
`ifdef UART_MSG_TX_CHECKSUM_EN
                    csum_d  = csum_q ^ shift_q[7:0];
                    if (bcnt_q == LAST_BYTE) state_d = ST_CSUM;
`else
                    if (bcnt_q == LAST_BYTE) begin
                        state_d = POST_ST;
                        gcnt_d  = '0;
                    end
`endif
                end
            end
`ifdef UART_MSG_TX_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_byte  = csum_q;
                if (tx_ready) begin
                    state_d = POST_ST;
                    gcnt_d  = '0;
                end
            end
`endif
            ST_GAP: begin
                gcnt_d = gcnt_q + GW'(1);
                if (gcnt_q == LAST_GAP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
- Downstream neighbour of the test-harness controller.
- Accepts one complete UART message from the controller via the uart_out_req / uart_out_ready handshake.
- Serialises the message into bytes, LSB byte first (header byte goes first), to the byte-level UART transmitter over a valid/ready interface.
- Holds off further messages until the current one, plus an inter-message gap, has been fully sent.

Parameters:
- MSG_BYTES, 4: message width in bytes; uart_out_msg is MSG_BYTES*8 bits.
- GAP_CYCLES, 16: idle clock cycles enforced after the last byte is accepted, before uart_out_ready reasserts; 0 means no gap.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous active-low reset.
- uart_out_msg  input  MSG_BYTES*8  message from controller; sampled only on handshake.
- uart_out_req  input  1  controller send request.
- uart_out_ready  output  1  block can accept a message this cycle.
- tx_byte  output  8  byte to UART transmitter.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  UART transmitter accepts tx_byte this cycle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk; reset n_reset is asynchronous, active-low.
- Reset values:
  - uart_out_ready=0 while n_reset is low; 1 from the first clock after release.
  - tx_valid=0, tx_byte=0, busy=0.
  - Internal shift register, byte counter and gap counter cleared; state=IDLE.
- States: IDLE, SEND, CSUM (optional feature only), GAP.
- IDLE:
  - uart_out_ready=1, combinationally decoded from state.
  - Message accepted in cycle N when uart_out_req && uart_out_ready; uart_out_msg captured into the shift register.
  - Next state SEND.
  - uart_out_req while not ready is ignored; the message is not latched.
- SEND:
  - tx_valid=1, tx_byte = shift register bits [7:0]. First byte is presented in cycle N+1.
  - Byte transfer on tx_valid && tx_ready: shift right 8, increment byte counter.
  - tx_byte must be stable while tx_valid && !tx_ready; tx_valid never drops before the transfer.
  - After byte MSG_BYTES-1 transfers: go to GAP (or CSUM if enabled).
  - With tx_ready held high, exactly one byte per cycle and no bubble between bytes.
- GAP:
  - tx_valid=0; counter runs GAP_CYCLES cycles, then IDLE.
  - If GAP_CYCLES=0, go directly to IDLE after the last byte.
- Byte counter width: $clog2(MSG_BYTES+1). Gap counter width: $clog2(GAP_CYCLES+1), minimum 1.
- uart_out_ready=0 in all non-IDLE states, so back-to-back messages are separated by at least the gap plus one cycle.
- tx_ready is ignored while tx_valid=0.
- Asynchronous reset mid-message: tx_valid drops immediately; the partial message is discarded and never resumed.
- Message contents are not interpreted; header validity is the controller's responsibility.

Optional Feature:
- Macro: UART_MSG_TX_CHECKSUM_EN.
- Defined:
  - After the last payload byte, enter CSUM.
  - Present tx_byte = XOR of all MSG_BYTES transmitted bytes, with the same valid/ready rules.
  - The checksum accumulator is cleared on message capture and updated on each byte transfer.
  - Then go to GAP.
- Undefined: CSUM state and accumulator are absent; SEND goes directly to GAP.

Decomposition:
- Shared package / header (alongside the existing UART message constants) holds:
  - MSG_BYTES default, derived from the UART message size constant.
  - State enum for this block.
  - Checksum width constant (8).
- No sub-module: shift register, counters and FSM are small enough to stay inline. The byte UART transmitter is an existing separate block instantiated by the parent.

Test Plan:
1. Send with continuous tx_ready: reset, tx_ready=1, msg=0xA1B2C3D4 with req in cycle N.
   - Bytes D4, C3, B2, A1 appear in cycles N+1..N+4.
   - uart_out_ready is low from N+1 until GAP_CYCLES cycles after the last byte, then high.
2. Back-pressure: tx_ready low for 5 cycles after the first valid.
   - tx_byte stays 0xD4 with tx_valid high throughout.
   - Remaining bytes follow in order once tx_ready rises; none are lost or duplicated.
3. Request while busy: second uart_out_req with 0x11111111 asserted during SEND.
   - Ignored; only 0xA1B2C3D4 bytes are emitted.
   - A later req in IDLE sends 11, 11, 11, 11.
4. Reset mid-operation: n_reset pulled low after the second byte.
   - tx_valid drops asynchronously; busy=0.
   - After release: ready=1 and no residual bytes are emitted.
5. Checksum (with UART_MSG_TX_CHECKSUM_EN): msg=0xA1B2C3D4.
   - Bytes D4, C3, B2, A1, then 0x04.
   - Without the macro, exactly 4 bytes are sent.
6. GAP_CYCLES=0 build: after the last byte transfers, uart_out_ready is high in the very next cycle; a new req there starts its first byte one cycle later.
